// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner
//
// Drives a 4-digit multiplexed seven-segment display from a slow scan clock
// level supplied by the clock divider. Each rising edge of seg_clk (sampled in
// the clk domain) advances to the next digit. Between digits all anodes are
// held off for BLANK_CYCLES clk cycles to prevent ghosting.
//
// New display values enter through a valid/ready handshake into a pending
// buffer and are copied to the shadow (displayed) buffer only when the scan
// wraps from digit 3 to digit 0, so a frame never shows a mix of two values.
//
// Handshake: a transfer happens on a clk edge where value_valid && value_ready.
// value_ready is a register equal to "pending buffer empty". The source holds
// value_in/dp_in/value_valid stable while value_ready is low; nothing is ever
// dropped or overwritten.
//
// Ports:
//   clk          in   master clock
//   rst_n        in   asynchronous active-low reset
//   seg_clk      in   scan clock level, synchronous to clk
//   value_in     in   [15:0] four hex digits, digit0 = [3:0]
//   dp_in        in   [3:0] decimal point per digit, 1 = lit
//   value_valid  in   value_in/dp_in offered
//   value_ready  out  pending buffer empty
//   lz_en        in   leading-zero suppression enable (sampled live)
//   an           out  [3:0] anodes, active-low, an[i] selects digit i
//   seg          out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   dp           out  decimal point, active-low
//   frame_done   out  one-cycle pulse on the digit3 -> digit0 wrap
//   dbg_state    out  current scan state (0 = BLANK, 1 = SHOW)
// ============================================================================
module seven_seg_scanner #(
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_clk,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        value_valid,
    output logic        value_ready,
    input  logic        lz_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done,
    output logic        dbg_state
);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_seg_clk_q;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;

    logic [15:0]      r_shadow_val;
    logic [3:0]       r_shadow_dp;
    logic [15:0]      r_pend_val;
    logic [3:0]       r_pend_dp;
    logic             r_pend_full;
    logic             r_ready;

    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_done;

    logic             w_rise;
    logic             w_blank_done;
    logic             w_wrap;
    logic             w_accept;
    logic             w_pend_full_next;
    logic [3:0]       w_digit;
    logic             w_suppress;
    logic [6:0]       w_seg_lit;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_decode(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign w_rise       = seg_clk & ~r_seg_clk_q;
    assign w_blank_done = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
    assign w_wrap       = (r_state == ST_SHOW) && w_rise && (r_idx == 2'd3);
    assign w_accept     = value_valid && r_ready;

    // Accept only happens with pending empty, so it can never coincide with
    // a wrap that drains a full pending buffer.
    assign w_pend_full_next = w_accept ? 1'b1 :
                              (w_wrap ? 1'b0 : r_pend_full);

    // ------------------------------------------------------------------
    // FSM: state register + next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BLANK: if (w_blank_done) w_state_next = ST_SHOW;
            ST_SHOW:  if (w_rise)       w_state_next = ST_BLANK;
            default:                    w_state_next = ST_BLANK;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit select and leading-zero suppression for the digit about to be
    // shown. A digit is suppressed when it and every digit above it are 0;
    // digit0 is never suppressed so an all-zero value shows "0".
    // ------------------------------------------------------------------
    always_comb begin
        w_digit    = r_shadow_val[3:0];
        w_suppress = 1'b0;
        case (r_idx)
            2'd0: begin
                w_digit    = r_shadow_val[3:0];
                w_suppress = 1'b0;
            end
            2'd1: begin
                w_digit    = r_shadow_val[7:4];
                w_suppress = lz_en && (r_shadow_val[15:4] == 12'h000);
            end
            2'd2: begin
                w_digit    = r_shadow_val[11:8];
                w_suppress = lz_en && (r_shadow_val[15:8] == 8'h00);
            end
            default: begin
                w_digit    = r_shadow_val[15:12];
                w_suppress = lz_en && (r_shadow_val[15:12] == 4'h0);
            end
        endcase
        w_seg_lit = w_suppress ? 7'h7F : hex_decode(w_digit);
    end

    // ------------------------------------------------------------------
    // Scan datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_clk_q  <= 1'b0;
            r_cnt        <= '0;
            r_idx        <= 2'd0;
            r_an         <= 4'hF;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_seg_clk_q  <= seg_clk;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_BLANK: begin
                    // Rises during blanking are deliberately ignored.
                    if (w_blank_done) begin
                        r_cnt <= '0;
                        r_an  <= ~(4'b0001 << r_idx);
                        r_seg <= w_seg_lit;
                        r_dp  <= ~r_shadow_dp[r_idx];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (w_rise) begin
                        r_an         <= 4'hF;
                        r_seg        <= 7'h7F;
                        r_dp         <= 1'b1;
                        r_idx        <= r_idx + 2'd1;
                        r_cnt        <= '0;
                        r_frame_done <= (r_idx == 2'd3);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending (handshake side) -> shadow (display side)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_val <= 16'h0000;
            r_shadow_dp  <= 4'h0;
            r_pend_val   <= 16'h0000;
            r_pend_dp    <= 4'h0;
            r_pend_full  <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            if (w_wrap && r_pend_full) begin
                r_shadow_val <= r_pend_val;
                r_shadow_dp  <= r_pend_dp;
            end
            if (w_accept) begin
                r_pend_val <= value_in;
                r_pend_dp  <= dp_in;
            end
            r_pend_full <= w_pend_full_next;
            r_ready     <= ~w_pend_full_next;
        end
    end

    assign value_ready = r_ready;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign frame_done  = r_frame_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// tb_seven_seg_scanner
//
// Table-driven bench for seven_seg_scanner: each table record holds a value,
// its dp bits, lz_en and the four expected segment patterns (hand-decoded).
// Hand-written sequences cover reset release, blanking length with a stray
// rise, backpressure and asynchronous reset mid-scan.
// ============================================================================
module tb_seven_seg_scanner;

    logic        clk;
    logic        rst_n;
    logic        seg_clk;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        value_valid;
    logic        value_ready;
    logic        lz_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;
    logic        dbg_state;

    seven_seg_scanner #(
        .BLANK_CYCLES(16),
        .CNT_W(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_clk    (seg_clk),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .lz_en      (lz_en),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        lz;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    // ---------------- scoreboard state ----------------
    int         n_vec;
    int         n_err;
    int         exp_idx;
    bit         hold_drop;
    int         accepts;
    int         accepts_at_boundary;
    logic [27:0] prev_segs;
    logic       prev_lz;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t idx=%0d)", name, act, exp, $time, exp_idx);
        end
    endtask

    // Count blank cycles (an == F) from the current sample until a digit is
    // lit, optionally injecting a second seg_clk rise inside the window.
    task automatic blank_wait(input bit inject, input bit fd_in);
        int         blanks;
        bit         drop_next;
        logic [3:0] exp_an;
        blanks    = 0;
        drop_next = 0;
        while (an == 4'hF && blanks < 40) begin
            blanks++;
            if (blanks == 1) chk("blank_seg", {25'd0, seg}, 32'h7F);
            if (blanks == 1) chk("blank_dp", {31'd0, dp}, 32'd1);
            if (blanks == 2) chk("fd_width", {31'd0, frame_done}, 32'd0);
            if (blanks == 2 && fd_in && !hold_drop)
                chk("ready_after_fd", {31'd0, value_ready}, 32'd1);
            if (inject && blanks == 6) seg_clk = 1'b1;
            if (inject && blanks == 7) seg_clk = 1'b0;
            if (hold_drop) begin
                if (drop_next) begin
                    value_valid = 1'b0;
                    drop_next   = 0;
                    accepts++;
                    if (fd_in) accepts_at_boundary++;
                end else if (value_valid && value_ready) begin
                    drop_next = 1;
                end
            end
            @(negedge clk);
        end
        chk("blank_len", blanks, 32'd16);
        exp_an = ~(4'b0001 << exp_idx);
        chk("anode", {28'd0, an}, {28'd0, exp_an});
    endtask

    // Produce one seg_clk rise while a digit is shown and follow it through
    // the blank window to the next lit digit.
    task automatic step_digit(input bit inject, output bit fd);
        seg_clk = 1'b1;
        @(negedge clk);
        seg_clk = 1'b0;
        fd = frame_done;
        chk("fd_pulse", {31'd0, frame_done}, {31'd0, (exp_idx == 3)});
        chk("an_off", {28'd0, an}, 32'hF);
        exp_idx = (exp_idx + 1) % 4;
        blank_wait(inject, fd);
    endtask

    task automatic apply_vec(input vec_t v);
        bit         fd;
        int         steps;
        bit         same_lz;
        logic [7:0] e;
        lz_en = v.lz;
        chk("ready_idle", {31'd0, value_ready}, 32'd1);
        value_in    = v.val;
        dp_in       = v.dpi;
        value_valid = 1'b1;
        @(negedge clk);
        value_valid = 1'b0;
        chk("ready_drop", {31'd0, value_ready}, 32'd0);
        same_lz = (v.lz == prev_lz);
        fd    = 0;
        steps = 0;
        while (!fd && steps < 8) begin
            step_digit(1'b0, fd);
            steps++;
            if (!fd) begin
                chk("ready_hold", {31'd0, value_ready}, 32'd0);
                if (same_lz) chk("old_seg", {25'd0, seg}, {25'd0, prev_segs[exp_idx*7 +: 7]});
            end
        end
        chk("boundary_seen", {31'd0, fd}, 32'd1);
        for (int d = 0; d < 4; d++) exp_q.push_back({v.segs[d*7 +: 7], ~v.dpi[d]});
        for (int d = 0; d < 4; d++) begin
            if (d > 0) step_digit(d == 1, fd);
            e = exp_q.pop_front();
            chk("vec_seg", {25'd0, seg}, {25'd0, e[7:1]});
            chk("vec_dp", {31'd0, dp}, {31'd0, e[0]});
        end
        prev_segs = v.segs;
        prev_lz   = v.lz;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit fd;
        n_vec = 0; n_err = 0; exp_idx = 0;
        hold_drop = 0; accepts = 0; accepts_at_boundary = 0;
        prev_segs = {7'h40, 7'h40, 7'h40, 7'h40};
        prev_lz   = 1'b0;

        vecs[0] = '{16'h12AF, 4'b0001, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h12}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0005, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h12}};
        vecs[4] = '{16'h3456, 4'b1010, 1'b0, {7'h30, 7'h19, 7'h12, 7'h02}};
        vecs[5] = '{16'h0780, 4'b0100, 1'b1, {7'h7F, 7'h78, 7'h00, 7'h40}};
        vecs[6] = '{16'h9BCD, 4'b1111, 1'b1, {7'h10, 7'h03, 7'h46, 7'h21}};
        vecs[7] = '{16'hE00E, 4'b0000, 1'b1, {7'h06, 7'h40, 7'h40, 7'h06}};
        vecs[8] = '{16'h0010, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h40}};

        rst_n = 1'b1; seg_clk = 1'b0; value_in = '0; dp_in = '0;
        value_valid = 1'b0; lz_en = 1'b0;

        // Reset assertion (async) and reset values.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        chk("rst_ready", {31'd0, value_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Blank for exactly 16 cycles, then digit0 shows 0.
        blank_wait(1'b0, 1'b0);
        chk("rel_seg", {25'd0, seg}, 32'h40);
        chk("rel_dp", {31'd0, dp}, 32'd1);

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) apply_vec(vecs[i]);

        // Backpressure: 1111 accepted, 2222 held until the next boundary.
        lz_en = 1'b0;
        chk("bp_ready0", {31'd0, value_ready}, 32'd1);
        value_in = 16'h1111; dp_in = 4'h0; value_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_low", {31'd0, value_ready}, 32'd0);
        value_in  = 16'h2222;
        hold_drop = 1;
        step_digit(1'b0, fd);                 // digit3 -> digit0, boundary
        chk("bp_boundary", {31'd0, fd}, 32'd1);
        chk("bp_accept_once", accepts, 32'd1);
        chk("bp_accept_at_fd", accepts_at_boundary, 32'd1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) begin
                step_digit(1'b0, fd);
                chk("bp_ready_hold", {31'd0, value_ready}, 32'd0);
            end
            chk("bp_seg_1111", {25'd0, seg}, 32'h79);
        end
        step_digit(1'b0, fd);
        chk("bp_no_reaccept", accepts, 32'd1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) step_digit(1'b0, fd);
            chk("bp_seg_2222", {25'd0, seg}, 32'h24);
        end
        hold_drop = 0;

        // Async reset while digit2 is shown.
        step_digit(1'b0, fd);
        step_digit(1'b0, fd);
        step_digit(1'b0, fd);
        chk("ar_pre_an", {28'd0, an}, 32'hB);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_an", {28'd0, an}, 32'hF);
        chk("ar_seg", {25'd0, seg}, 32'h7F);
        chk("ar_ready", {31'd0, value_ready}, 32'd1);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_idx = 0;
        blank_wait(1'b0, 1'b0);
        chk("ar_seg0", {25'd0, seg}, 32'h40);
        step_digit(1'b0, fd);
        chk("ar_seg1", {25'd0, seg}, 32'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Consumes the slow scan clock from the clock divider and drives a 4-digit multiplexed seven-segment display.
Each digit is lit in turn, with a fixed anti-ghosting blank interval between digits.
New display values arrive through a valid/ready handshake and are double-buffered, so they are applied only at a frame boundary and the display never tears.
The block sits between the result logic (classifier output, status) and the board's anode/segment pins.

Parameters:
BLANK_CYCLES, 16, clk cycles with all anodes off after each digit switch; legal range >= 1
CNT_W, 8, width of blank counter; must satisfy 2^CNT_W > BLANK_CYCLES

Ports:
clk  in  1  master clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
seg_clk  in  1  scan clock level from the divider, synchronous to clk; each rising edge advances one digit
value_in  in  16  four hex digits; digit0 = [3:0] ... digit3 = [15:12]
dp_in  in  4  decimal point per digit, 1 = lit
value_valid  in  1  value_in/dp_in offered
value_ready  out  1  pending buffer empty; a transfer occurs when valid && ready
lz_en  in  1  leading-zero suppression enable
an  out  4  anodes, active-low, an[i] selects digit i
seg  out  7  segments, active-low, seg[6:0] = g f e d c b a
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0

Behaviour:
- Reset (asynchronous; takes effect immediately with no clk edge required):
  - an=4'hF, seg=7'h7F, dp=1, frame_done=0, value_ready=1
  - idx=0, shadow value=0, shadow dp=0, pending empty, seg_clk_q=0
  - state=BLANK, cnt=0
- Edge detect: seg_clk_q <= seg_clk every cycle; rise = seg_clk & ~seg_clk_q.
- State BLANK:
  - an=4'hF.
  - cnt increments each cycle. On the edge where cnt==BLANK_CYCLES-1, go to SHOW and register an/seg/dp for idx. BLANK therefore lasts exactly BLANK_CYCLES cycles.
  - A rise seen during BLANK is ignored (dropped, not queued).
- State SHOW:
  - an[idx]=0, all other anodes 1. seg = decode of the shadow digit idx. dp = ~shadow_dp[idx].
  - On rise: next edge sets an=4'hF, idx=(idx+1) mod 4, cnt=0, state=BLANK.
  - If idx was 3: frame_done=1 for that one cycle, and if pending is full, shadow <= pending and pending is cleared.
- Handshake:
  - value_ready is registered and equals ~pending_full.
  - On valid&&ready, capture value_in and dp_in into pending and set pending_full; value_ready=0 from the next cycle.
  - An accept in the same cycle as a frame boundary lands in pending and is applied at the following boundary.
  - value_in and value_valid are held by the source while ready=0. Nothing is ever dropped or overwritten.
- Decode (active-low), 0..F:
  - 0-7: 40,79,24,30,19,12,02,78
  - 8-F: 00,10,08,03,46,21,06,0E
- Leading-zero suppression (lz_en=1):
  - Digits above the most significant nonzero shadow digit output seg=7'h7F.
  - digit0 always shows its value (0x0000 displays "0").
  - dp is unaffected by suppression.
  - lz_en is sampled live, so a change takes effect from the next SHOW entry.
- All outputs are registered; no combinational path from any input to an, seg or dp.

Test Plan:
- Reset release: rst_n 0->1 -> an=4'hF, seg=7'h7F, dp=1, ready=1 for exactly 16 cycles, then an=4'hE, seg=7'h40.
- Load 16'h12AF, dp_in=4'b0001: ready drops next cycle and the display stays 0 until frame_done. In the following frame:
  - digit0: seg=0E, dp=0
  - digit1: seg=08
  - digit2: seg=24
  - digit3: seg=79
  - ready=1 the cycle after frame_done.
- Blanking: seg_clk rise in SHOW -> next cycle an=4'hF for exactly 16 cycles, then the next anode goes low. A second rise inside that window does not advance idx.
- Leading zeros, lz_en=1:
  - 16'h0005: digits 3..1 seg=7F, digit0 seg=12
  - 16'h0000: digit0 seg=40
  - lz_en=0 with 16'h0005: digits 3..1 show 40
- Backpressure: offer 16'h1111 then hold 16'h2222 valid -> second accepted only after the next frame_done. Exactly one full frame of 1111, then 2222; no value lost.
- Async reset mid-SHOW with idx=2: rst_n low between clk edges -> an=4'hF and seg=7'h7F immediately. After release the scan restarts at digit0 showing 0.
